// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int          MD_ITERS   = 32;
  localparam int          MD_CNT_W   = $clog2(MD_ITERS);
  localparam logic [31:0] MD_DIVZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EXE/ID-side handshake and HI/LO read bus of the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations, reads HI/LO.
  modport master (
    output start, op, rs_val, rt_val, flush, hilo_rd,
    input  busy, done, stall, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, rs_val, rt_val, flush, hilo_rd,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the 64-bit working register.
//   multiply: {partial_hi, multiplier} -- add multiplicand if bit0, shift right.
//   divide:   {remainder, dividend/quotient} -- shift left, restoring subtract.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH:0]   trial;

  // Single shift-add / shift-subtract iteration; carries are kept in the extra MSB.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    acc_o   = '0;
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    shl     = {acc_i, 1'b0};
    trial   = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
    if (!is_div) begin
      if (acc_i[0]) acc_o = {add_sum, acc_i[WIDTH-1:1]};
      else          acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_o = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      acc_o = shl[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Operates on magnitudes for 32 iterations, then applies sign correction in FIX.
// HI/LO and done are registered on the edge that leaves FIX.
// Optional: define MULDIV_EARLY_OUT_EN to finish trivially-zero operations in 2 cycles.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam logic [MD_CNT_W-1:0] LAST_CNT = MD_CNT_W'(MD_ITERS - 1);

  md_state_t            state_q, state_d;
  logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic                 divz_q, divz_d, done_q, done_d;

  logic                 op_div, op_signed, rs_neg, rt_neg, early_out, busy;
  logic [WIDTH-1:0]     rs_mag, rt_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Issue-side decode: magnitudes, result signs and the optional early-out test.
  always_comb begin
    op_div    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
    op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    rs_neg    = op_signed & bus.rs_val[WIDTH-1];
    rt_neg    = op_signed & bus.rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
`ifdef MULDIV_EARLY_OUT_EN
    early_out = op_div ? ((bus.rs_val == '0) && (bus.rt_val != '0))
                       : ((bus.rs_val == '0) || (bus.rt_val == '0));
`else
    early_out = 1'b0;
`endif
  end

  // Sign correction of the magnitude result; divide-by-zero forces LO to all ones.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (divz_q) quo_fix = MD_DIVZ_LO;
  end

  // FSM next state, datapath loads and HI/LO update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opnd_d   = op_div ? rt_mag : rs_mag;
          acc_d    = op_div ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
          is_div_d = op_div;
          neg_d    = rs_neg ^ rt_neg;
          rneg_d   = rs_neg;
          divz_d   = op_div && (bus.rt_val == '0);
          cnt_d    = '0;
          state_d  = RUN;
          if (early_out) begin
            acc_d   = '0;
            state_d = FIX;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // Control state and architectural HI/LO, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Working datapath registers, always loaded at issue before use.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; these are overwritten on every issue and never observed before that.
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    divz_q   <= divz_d;
  end

  // Busy covers the whole operation up to and including the done cycle.
  always_comb begin
    busy      = (state_q != IDLE) | done_q;
    bus.busy  = busy;
    bus.done  = done_q;
    bus.stall = busy & bus.hilo_rd;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

endmodule
